// File: rtl/bit_serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package bit_serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/bit_serial_adder_full_adder.sv
// One-bit full adder built from two half-adder cells and an OR on the carries.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module full_adder (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s,
    output logic c
);
    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (.x(x),  .y(y), .s(s0), .c(c0));
    half_adder u_ha1 (.x(s0), .y(z), .s(s),  .c(c1));

    assign c = c0 | c1;
endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: adds a + b + cin one bit per cycle, LSB first, through a single full adder.
// Handshake: start is sampled only in IDLE/DONE; busy is high exactly in RUN; done pulses for the one DONE cycle.
module bit_serial_adder
    import bit_serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] sum_sh;
    logic [WIDTH-1:0] sum_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_c;
    logic             accept;
    logic             last;

    assign accept  = (state != RUN) && start;
    assign last    = (state == RUN) && (cnt == LAST);
    // Previous sum bits plus this cycle's bit; on the last RUN cycle this is the full result.
    assign sum_nxt = {fa_s, sum_sh};

    full_adder u_fa (
        .x (a_sh[0]),
        .y (b_sh[0]),
        .z (carry),
        .s (fa_s),
        .c (fa_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? RUN : IDLE;
            RUN:     state_nxt = last ? DONE : RUN;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == RUN);
        done      = (state == DONE);
        dbg_state = state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            sum_sh <= '0;
            carry  <= cin;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= sum_nxt[WIDTH-1:1];
            carry  <= fa_c;
            cnt    <= cnt + CW'(1);
        end
    end

    // Visible result only moves on entry to DONE and holds through the next RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (last) begin
            sum  <= sum_nxt;
            cout <= fa_c;
        end
    end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder (WIDTH=8): directed scenarios plus 1000 random adds.
module tb_bit_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic [1:0]   dbg_state;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [W:0] exp_q[$];
    int         stamp_q[$];
    logic [W:0] last_res = '0;

    bit_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .cout      (cout),
        .dbg_state (dbg_state)
    );

    // Clock and edge counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, expv, cyc);
        end
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    // Monitor: pops the scoreboard on every done, otherwise the result must hold.
    always @(negedge clk) begin
        logic [W:0] e;
        int         s;
        if (rst_n) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("spurious_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    s = stamp_q.pop_front();
                    check("result", int'({cout, sum}), int'(e));
                    check("latency", cyc - s, W);
                    last_res = e;
                end
            end else begin
                check("hold", int'({cout, sum}), int'(last_res));
            end
        end
    end

    // Wait (bounded) for done; returns edge count of done or -1.
    task automatic wait_done(output int done_at);
        done_at = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin
                done_at = cyc;
                break;
            end
        end
        if (done_at < 0) check("done_timeout", 0, 1);
    endtask

    // One operation; poke >= 0 raises start with zero operands that many cycles into RUN.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                          input int poke, output int busy_n);
        int done_at;
        a = ta;
        b = tb;
        cin = tc;
        start = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(ref_add(ta, tb, tc));
        stamp_q.push_back(cyc);
        start = 1'b0;
        busy_n = 0;
        done_at = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == poke) begin
                start = 1'b1;
                a = '0;
                b = '0;
                cin = 1'b0;
            end else if (i == poke + 1) begin
                start = 1'b0;
            end
            if (poke < 0 && i == 1) begin
                a = W'($urandom);
                b = W'($urandom);
                cin = 1'($urandom_range(0, 1));
            end
            if (done) begin
                done_at = cyc;
                break;
            end
            if (busy) busy_n++;
        end
        start = 1'b0;
        if (done_at < 0) begin
            check("done_timeout", 0, 1);
        end else begin
            @(negedge clk);
            check("done_pulse_len", int'(done), 0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int bn;
        int d1;
        int d2;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_sum", int'(sum), 0);
        check("rst_cout", int'(cout), 0);
        check("rst_state", int'(dbg_state), 0);
        rst_n = 1'b1;

        // Basic add, accepted on the first edge after reset release
        run_op(8'h5A, 8'h3C, 1'b0, -1, bn);
        check("basic_busy_cycles", bn, W);

        // Wrap-around
        run_op(8'hFF, 8'h01, 1'b0, -1, bn);
        run_op(8'hFF, 8'hFF, 1'b1, -1, bn);

        // Start during RUN ignored
        run_op(8'h10, 8'h20, 1'b0, 2, bn);
        check("ignore_busy_cycles", bn, W);

        // Back-to-back: start held high through the first DONE
        a = 8'h33;
        b = 8'h44;
        cin = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(ref_add(8'h33, 8'h44, 1'b0));
        stamp_q.push_back(cyc);
        a = 8'h01;
        b = 8'h02;
        cin = 1'b1;
        wait_done(d1);
        @(posedge clk);
        #1;
        exp_q.push_back(ref_add(8'h01, 8'h02, 1'b1));
        stamp_q.push_back(cyc);
        start = 1'b0;
        wait_done(d2);
        if (d1 >= 0 && d2 >= 0) check("b2b_gap", d2 - d1, W + 1);
        @(negedge clk);
        check("b2b_done_pulse_len", int'(done), 0);
        @(posedge clk);
        #1;

        // Reset mid-operation: partial result discarded, no done
        a = 8'hAB;
        b = 8'hCD;
        cin = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_sum", int'(sum), 0);
        check("midrst_cout", int'(cout), 0);
        last_res = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        run_op(8'h80, 8'h80, 1'b0, -1, bn);

        // Random operations
        for (int n = 0; n < 1000; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom_range(0, 1));
            run_op(ra, rb, rc, -1, bn);
        end

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1ms;
        total++;
        bad++;
        $display("FAIL watchdog actual=running required=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
